ol_argmax_stream: RTL and testbench
===================================

// Module: ol_argmax_stream
// PURPOSE
//  Streaming argmax over one frame of IEEE-754 output-layer scores (one score per class).
//  Accepts one score per cycle on a valid/ready input.
//  Emits the index and value of the largest score once per frame.
//  Sits between the output-layer PE array and the classification result register.
//  Replaces the fixed 10-input findmax with a parametrised, back-pressured, frame-based unit.
// PARAMETERS
//  NUM_CLASSES  10   scores per full frame; must be >= 2
//  EXP_W        8    float exponent width
//  MAN_W        23   float mantissa width; DATA_W = 1+EXP_W+MAN_W (32 = single precision)
//  IDX_W        $clog2(NUM_CLASSES)  class index width
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       in_data/in_last valid
//  in_ready   out  1       block can accept a score
//  in_data    in   DATA_W  score, IEEE-754 format
//  in_last    in   1       final score of a short frame
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer accepts result
//  out_idx    out  IDX_W   index of the maximum score
//  out_val    out  DATA_W  maximum score, as received
//  out_len    out  IDX_W+1 number of scores in the frame
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=1; out_valid=0; out_idx, out_val, out_len and the count are 0.
//    Reset asserted mid-frame discards the partial frame.
//  - FSM states:
//    - IDLE: no score held.
//    - ACCUM: frame open. IDLE->ACCUM on the first accepted score.
//    - DONE: result held.
//  - in_ready = (state != DONE).
//  - A score is accepted on a cycle where in_valid & in_ready.
//    - The first score of a frame loads max/idx unconditionally with index 0.
//    - Each later score (index = count) replaces max/idx only if strictly greater. Ties keep the lower index.
//  - Compare key:
//    - -0 is canonicalised to +0 before the compare.
//    - NaN (exp all-ones, mantissa != 0) gets the key of the minimum, ranking below -inf.
//    - Otherwise key = sign ? ~x : x | (1<<(DATA_W-1)); keys compare as unsigned.
//    - out_val always returns the original bits, never the canonicalised form.
//  - Frame close happens on the accepted score where in_last=1 or count==NUM_CLASSES-1.
//    - If both conditions hold, the frame closes once.
//    - If a full frame arrives without in_last, it still closes.
//    - An in_last arriving on a later score belongs to the next frame.
//  - On close, state goes to DONE. out_valid is registered high the cycle after the last accept (latency 1).
//    out_idx/out_val/out_len update on that same edge.
//  - In DONE, outputs stay stable while out_valid & !out_ready.
//    - The out_valid & out_ready handshake returns the FSM to IDLE. The count clears to 0.
//    - out_valid drops on that edge. out_idx/out_val/out_len keep their last values.
//    - in_ready stays low in DONE, so there is one bubble per frame minimum.
//  - A single-score frame (in_last on the first score) gives out_idx=0 and out_len=1.
//  - If every score is NaN, the result is idx 0 and out_val = the first NaN.
// CONFIGURATION
//  OL_ARGMAX_TOP2_EN defined:
//    - Adds output ports out_idx2 [IDX_W] and out_val2 [DATA_W], giving the runner-up.
//    - A new max pushes the old max to second place.
//    - Otherwise a score strictly greater than the second-best replaces it. Ties keep the lower index.
//    - For a 1-score frame, out_idx2=0 and out_val2=0.
//    - Both ports reset to 0.
//  OL_ARGMAX_TOP2_EN undefined: the ports are absent and no second-best logic is generated.
// STRUCTURE
//  - Package ol_argmax_pkg holds:
//    - the state enum (IDLE/ACCUM/DONE)
//    - function fp_key(DATA_W bits) -> DATA_W unsigned key, which handles NaN and -0
//    - localparams for the NaN/zero masks, derived from EXP_W/MAN_W
//  - One sub-module: ol_fp_gt (combinational strict greater-than on two scores, using fp_key).
//    It is instantiated once for max and a second time under OL_ARGMAX_TOP2_EN.
// TESTING
//  1. Full frame 10.0,20.0,...,100.0 (41200000..42C80000), no in_last
//     -> out_idx=9, out_val=42C80000, out_len=10, out_valid the cycle after the 10th accept.
//  2. Same values with 100.0 rotated to index k, for k=9..0, back-to-back frames with out_ready=1
//     -> out_idx=k each frame; in_ready low exactly one cycle per frame.
//  3. Ties and zeros: frame {-0, +0, 5.0, 5.0, 0xFFC00000 NaN, -inf, ...}
//     -> out_idx=2; the NaN never wins; an all-NaN frame -> out_idx=0.
//  4. Short frame with in_last on the 4th score {-3.0, -1.0, -2.0, -8.0} -> out_idx=1, out_len=4.
//  5. Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1
//     -> outputs stable, no score accepted; release -> next frame starts cleanly.
//  6. Assert rst_n low mid-frame after 6 scores -> out_valid=0 and in_ready=1 immediately;
//     a new full frame gives the correct result.
//     With OL_ARGMAX_TOP2_EN, test 1 also gives out_idx2=8, out_val2=42B40000.

Source files
------------

// File: rtl/ol_argmax_pkg.sv
// Shared types and the float ordering key for the streaming argmax block.
// The key maps IEEE-754 bit patterns onto an unsigned order: NaN lowest, -0 folded onto +0.
package ol_argmax_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_EXP_W  = 8;
  localparam int DEF_MAN_W  = 23;
  localparam int DEF_DATA_W = 1 + DEF_EXP_W + DEF_MAN_W;

  localparam logic [DEF_DATA_W-1:0] SIGN_MASK = {1'b1, {(DEF_DATA_W-1){1'b0}}};
  localparam logic [DEF_DATA_W-1:0] EXP_MASK  = {1'b0, {DEF_EXP_W{1'b1}}, {DEF_MAN_W{1'b0}}};
  localparam logic [DEF_DATA_W-1:0] MAN_MASK  = {{(1+DEF_EXP_W){1'b0}}, {DEF_MAN_W{1'b1}}};

  // Keys are built in a 64-bit container so any format up to double precision shares one function.
  localparam int KEY_W = 64;

  function automatic logic [KEY_W-1:0] fp_key(input logic [KEY_W-1:0] x,
                                              input int exp_w,
                                              input int man_w);
    logic [KEY_W-1:0] sign_bit;
    logic [KEY_W-1:0] man_mask;
    logic [KEY_W-1:0] exp_mask;
    logic [KEY_W-1:0] mag_mask;
    logic [KEY_W-1:0] xm;
    logic [KEY_W-1:0] key;
    sign_bit = KEY_W'(1) << (exp_w + man_w);
    man_mask = (KEY_W'(1) << man_w) - KEY_W'(1);
    exp_mask = ((KEY_W'(1) << exp_w) - KEY_W'(1)) << man_w;
    mag_mask = exp_mask | man_mask;
    xm       = x & (sign_bit | mag_mask);
    if (((xm & exp_mask) == exp_mask) && ((xm & man_mask) != '0)) begin
      key = '0;
    end else if (xm == sign_bit) begin
      key = sign_bit;
    end else if ((xm & sign_bit) != '0) begin
      key = ~xm & mag_mask;
    end else begin
      key = xm | sign_bit;
    end
    return key;
  endfunction

endpackage

// File: rtl/ol_fp_gt.sv
// Combinational strict greater-than between two IEEE-754 scores.
// Ordering follows fp_key, so NaN never beats anything and -0 equals +0.
module ol_fp_gt
  import ol_argmax_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  localparam int DATA_W = 1 + EXP_W + MAN_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              gt
);

  logic [KEY_W-1:0] key_a;
  logic [KEY_W-1:0] key_b;

  assign key_a = fp_key(KEY_W'(a), EXP_W, MAN_W);
  assign key_b = fp_key(KEY_W'(b), EXP_W, MAN_W);
  assign gt    = (key_a > key_b);

endmodule

// File: rtl/ol_argmax_stream.sv
// Streaming argmax over one frame of float scores with valid/ready on both sides.
// Define OL_ARGMAX_TOP2_EN to add the runner-up outputs out_idx2/out_val2.
module ol_argmax_stream
  import ol_argmax_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int EXP_W       = DEF_EXP_W,
  parameter int MAN_W       = DEF_MAN_W,
  parameter int IDX_W       = $clog2(NUM_CLASSES),
  localparam int DATA_W     = 1 + EXP_W + MAN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [DATA_W-1:0] out_val,
`ifdef OL_ARGMAX_TOP2_EN
  output logic [IDX_W-1:0]  out_idx2,
  output logic [DATA_W-1:0] out_val2,
`endif
  output logic [IDX_W:0]    out_len
);

  state_t             state;
  state_t             next_state;
  logic [IDX_W-1:0]   count;
  logic [IDX_W-1:0]   max_idx;
  logic [DATA_W-1:0]  max_val;
  logic [IDX_W-1:0]   nxt_max_idx;
  logic [DATA_W-1:0]  nxt_max_val;
  logic               accept;
  logic               first_score;
  logic               last_slot;
  logic               close_frame;
  logic               handshake;
  logic               gt_max;

  assign in_ready    = (state != DONE);
  assign out_valid   = (state == DONE);
  assign accept      = in_valid & in_ready;
  assign first_score = (state == IDLE);
  assign last_slot   = (count == IDX_W'(NUM_CLASSES - 1));
  assign close_frame = accept & (in_last | last_slot);
  assign handshake   = out_valid & out_ready;

  ol_fp_gt #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_gt_max (
    .a  (in_data),
    .b  (max_val),
    .gt (gt_max)
  );

  // The first score of a frame seeds the running max regardless of its value.
  always_comb begin
    nxt_max_val = max_val;
    nxt_max_idx = max_idx;
    if (accept && (first_score || gt_max)) begin
      nxt_max_val = in_data;
      nxt_max_idx = count;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = close_frame ? DONE : ACCUM;
      ACCUM:   if (close_frame) next_state = DONE;
      DONE:    if (handshake) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // count is the index of the next score; it freezes in DONE until the result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      max_val <= '0;
      max_idx <= '0;
      out_idx <= '0;
      out_val <= '0;
      out_len <= '0;
    end else begin
      if (handshake) begin
        count <= '0;
      end else if (accept && !close_frame) begin
        count <= count + IDX_W'(1);
      end
      if (accept) begin
        max_val <= nxt_max_val;
        max_idx <= nxt_max_idx;
      end
      if (close_frame) begin
        out_idx <= nxt_max_idx;
        out_val <= nxt_max_val;
        out_len <= (IDX_W+1)'(count) + (IDX_W+1)'(1);
      end
    end
  end

`ifdef OL_ARGMAX_TOP2_EN
  logic [IDX_W-1:0]  sec_idx;
  logic [DATA_W-1:0] sec_val;
  logic              sec_valid;
  logic [IDX_W-1:0]  nxt_sec_idx;
  logic [DATA_W-1:0] nxt_sec_val;
  logic              nxt_sec_valid;
  logic              gt_sec;

  ol_fp_gt #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_gt_sec (
    .a  (in_data),
    .b  (sec_val),
    .gt (gt_sec)
  );

  // A displaced max becomes runner-up; an empty runner-up slot takes any non-winning score.
  always_comb begin
    nxt_sec_idx   = sec_idx;
    nxt_sec_val   = sec_val;
    nxt_sec_valid = sec_valid;
    if (accept) begin
      if (first_score) begin
        nxt_sec_idx   = '0;
        nxt_sec_val   = '0;
        nxt_sec_valid = 1'b0;
      end else if (gt_max) begin
        nxt_sec_idx   = max_idx;
        nxt_sec_val   = max_val;
        nxt_sec_valid = 1'b1;
      end else if (!sec_valid || gt_sec) begin
        nxt_sec_idx   = count;
        nxt_sec_val   = in_data;
        nxt_sec_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_idx   <= '0;
      sec_val   <= '0;
      sec_valid <= 1'b0;
      out_idx2  <= '0;
      out_val2  <= '0;
    end else begin
      sec_idx   <= nxt_sec_idx;
      sec_val   <= nxt_sec_val;
      sec_valid <= nxt_sec_valid;
      if (close_frame) begin
        out_idx2 <= nxt_sec_idx;
        out_val2 <= nxt_sec_val;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ol_argmax_stream.sv
// Randomised and directed bench for ol_argmax_stream against a frame-level argmax model.
// Honours OL_ARGMAX_TOP2_EN to also check the runner-up outputs.
module tb_ol_argmax_stream;

  localparam int NUM_CLASSES = 10;
  localparam int IDX_W       = 4;
  localparam int DATA_W      = 32;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    int          idx;
    logic [31:0] val;
    int          len;
    int          idx2;
    logic [31:0] val2;
  } res_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_idx;
  logic [DATA_W-1:0] out_val;
  logic [IDX_W:0]    out_len;
`ifdef OL_ARGMAX_TOP2_EN
  logic [IDX_W-1:0]  out_idx2;
  logic [DATA_W-1:0] out_val2;
`endif

  always #5 clk = ~clk;

  ol_argmax_stream #(
    .NUM_CLASSES (NUM_CLASSES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_val   (out_val),
`ifdef OL_ARGMAX_TOP2_EN
    .out_idx2  (out_idx2),
    .out_val2  (out_val2),
`endif
    .out_len   (out_len)
  );

  beat_t       src_q[$];
  logic [31:0] frame_q[$];
  res_t        model_log[$];
  int          dut_log_cnt;
  bit          exp_valid;
  res_t        exp_res;
  bit          rec_acc;
  bit          rec_hs;
  beat_t       rec_beat;
  int          checks;
  int          errors;
  int          valid_pct;
  int          ready_pct;
  int          ready_low_cnt;
  bit          count_ready_low;

  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Plain sign/magnitude ordering: true when a is strictly larger than b.
  function automatic bit beats(input logic [31:0] a, input logic [31:0] b);
    if (is_nan(a)) return 1'b0;
    if (is_nan(b)) return 1'b1;
    if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) return 1'b0;
    if (a[31] != b[31]) return !a[31];
    if (!a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  function automatic res_t model_result();
    res_t r;
    int   n;
    int   best;
    int   sec;
    r    = '{default: 0};
    n    = frame_q.size();
    best = 0;
    for (int i = 1; i < n; i++) begin
      if (beats(frame_q[i], frame_q[best])) best = i;
    end
    sec = -1;
    for (int i = 0; i < n; i++) begin
      if (i != best && (sec < 0 || beats(frame_q[i], frame_q[sec]))) sec = i;
    end
    r.idx = best;
    r.val = frame_q[best];
    r.len = n;
    if (sec >= 0) begin
      r.idx2 = sec;
      r.val2 = frame_q[sec];
    end
    return r;
  endfunction

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput();
    checkValue("out_valid", 64'(out_valid), 64'(exp_valid));
    checkValue("in_ready", 64'(in_ready), 64'(!exp_valid));
    checkValue("out_idx", 64'(out_idx), 64'(exp_res.idx));
    checkValue("out_val", 64'(out_val), 64'(exp_res.val));
    checkValue("out_len", 64'(out_len), 64'(exp_res.len));
`ifdef OL_ARGMAX_TOP2_EN
    checkValue("out_idx2", 64'(out_idx2), 64'(exp_res.idx2));
    checkValue("out_val2", 64'(out_val2), 64'(exp_res.val2));
`endif
  endtask

  task automatic model_accept(input beat_t b);
    frame_q.push_back(b.data);
    if (b.last || frame_q.size() == NUM_CLASSES) begin
      exp_res = model_result();
      model_log.push_back(exp_res);
      exp_valid = 1'b1;
      frame_q.delete();
    end
  endtask

  task automatic applyStimulus();
    in_valid = (src_q.size() != 0) && ($urandom_range(99) < valid_pct);
    if (in_valid) begin
      in_data = src_q[0].data;
      in_last = src_q[0].last;
    end else begin
      in_data = $urandom();
      in_last = 1'($urandom_range(1));
    end
    out_ready = ($urandom_range(99) < ready_pct);
  endtask

  // One cycle: fold in what the last rising edge did, compare, then drive the next inputs.
  task automatic step();
    @(negedge clk);
    if (rec_hs) exp_valid = 1'b0;
    if (rec_acc) model_accept(rec_beat);
    checkOutput();
    if (count_ready_low && !in_ready) ready_low_cnt++;
    applyStimulus();
    rec_acc = in_valid && !exp_valid;
    rec_hs  = exp_valid && out_ready;
    if (rec_acc) begin
      rec_beat = src_q[0];
      void'(src_q.pop_front());
    end
    if (rec_hs) dut_log_cnt++;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((src_q.size() != 0 || exp_valid || rec_acc || rec_hs || frame_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout actual=%0d cycles required=<%0d", name, n, budget);
    end
  endtask

  task automatic push_beat(input logic [31:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    src_q.push_back(b);
  endtask

  function automatic logic [31:0] rand_score();
    logic [31:0] specials[8];
    specials = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                 32'h7FC00000, 32'hFFC00000, 32'h3F800000, 32'h40A00000};
    case ($urandom_range(9))
      0, 1:    return specials[$urandom_range(7)];
      2:       return {1'($urandom_range(1)), 31'h40A00000};
      default: return $urandom();
    endcase
  endfunction

  task automatic do_reset_mid();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    frame_q.delete();
    exp_valid = 1'b0;
    exp_res   = '{default: 0};
    rec_acc   = 1'b0;
    rec_hs    = 1'b0;
    #1;
    checkValue("rst_mid_out_valid", 64'(out_valid), 64'd0);
    checkValue("rst_mid_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    checkOutput();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] ramp[10];
    logic [31:0] mixed[10];
    logic [31:0] nans[10];
    logic [31:0] shorts[4];
    int          n;
    int          len;

    ramp   = '{32'h41200000, 32'h41A00000, 32'h41F00000, 32'h42200000, 32'h42480000,
               32'h42700000, 32'h428C0000, 32'h42A00000, 32'h42B40000, 32'h42C80000};
    mixed  = '{32'h80000000, 32'h00000000, 32'h40A00000, 32'h40A00000, 32'hFFC00000,
               32'hFF800000, 32'h3F800000, 32'hBF800000, 32'h7FC00000, 32'h40000000};
    nans   = '{32'h7FC00000, 32'hFFC00001, 32'h7F800001, 32'hFF800010, 32'h7FFFFFFF,
               32'h7FC00000, 32'hFFFFFFFF, 32'h7F812345, 32'hFFC00000, 32'h7FA00000};
    shorts = '{32'hC0400000, 32'hBF800000, 32'hC0000000, 32'hC1000000};

    checks = 0; errors = 0; dut_log_cnt = 0; ready_low_cnt = 0; count_ready_low = 1'b0;
    exp_valid = 1'b0; exp_res = '{default: 0}; rec_acc = 1'b0; rec_hs = 1'b0;
    valid_pct = 100; ready_pct = 100;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput();
    rst_n = 1'b1;

    $display("[TB] full ascending frame");
    foreach (ramp[i]) push_beat(ramp[i], 1'b0);
    drain("t1", 100);

    $display("[TB] rotated maximum, back-to-back");
    count_ready_low = 1'b1;
    for (int k = 9; k >= 0; k--) begin
      for (int i = 0; i < 10; i++) push_beat(ramp[(i + 9 - k) % 10], 1'b0);
    end
    drain("t2", 400);
    count_ready_low = 1'b0;
    checkValue("t2_ready_low_cycles", 64'(ready_low_cnt), 64'd10);

    $display("[TB] ties, zeros and NaN");
    foreach (mixed[i]) push_beat(mixed[i], 1'b0);
    foreach (nans[i]) push_beat(nans[i], 1'b0);
    drain("t3", 200);

    $display("[TB] short frames");
    foreach (shorts[i]) push_beat(shorts[i], (i == 3));
    push_beat(32'h41200000, 1'b1);
    drain("t4", 100);

    $display("[TB] output backpressure");
    ready_pct = 0;
    for (int i = 0; i < 20; i++) push_beat(rand_score(), 1'b0);
    n = 0;
    while (!exp_valid && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL t5_wait timeout actual=%0d required=<100", n);
    end
    repeat (5) step();
    ready_pct = 100;
    drain("t5", 200);

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 6; i++) push_beat(rand_score(), 1'b0);
    n = 0;
    while ((src_q.size() != 0 || rec_acc) && n < 100) begin
      step();
      n++;
    end
    do_reset_mid();
    for (int i = 0; i < 10; i++) push_beat(rand_score(), 1'b0);
    drain("t6", 200);

    $display("[TB] random frames");
    valid_pct = 70;
    ready_pct = 60;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, NUM_CLASSES);
      for (int i = 0; i < len; i++) begin
        push_beat(rand_score(), (i == len - 1) && (len < NUM_CLASSES || $urandom_range(1) == 1));
      end
    end
    drain("random", 5000);

    if (model_log.size() < 15) begin
      checks++;
      errors++;
      $display("[TB] FAIL model_log_size actual=%0d required>=15", model_log.size());
    end else begin
      checkValue("lit_t1_idx", 64'(model_log[0].idx), 64'd9);
      checkValue("lit_t1_val", 64'(model_log[0].val), 64'h42C80000);
      checkValue("lit_t1_len", 64'(model_log[0].len), 64'd10);
`ifdef OL_ARGMAX_TOP2_EN
      checkValue("lit_t1_idx2", 64'(model_log[0].idx2), 64'd8);
      checkValue("lit_t1_val2", 64'(model_log[0].val2), 64'h42B40000);
`endif
      for (int j = 1; j <= 10; j++) begin
        checkValue("lit_t2_idx", 64'(model_log[j].idx), 64'(10 - j));
      end
      checkValue("lit_t3_idx", 64'(model_log[11].idx), 64'd2);
      checkValue("lit_t3_val", 64'(model_log[11].val), 64'h40A00000);
      checkValue("lit_nan_idx", 64'(model_log[12].idx), 64'd0);
      checkValue("lit_nan_val", 64'(model_log[12].val), 64'h7FC00000);
      checkValue("lit_t4_idx", 64'(model_log[13].idx), 64'd1);
      checkValue("lit_t4_val", 64'(model_log[13].val), 64'hBF800000);
      checkValue("lit_t4_len", 64'(model_log[13].len), 64'd4);
      checkValue("lit_one_idx", 64'(model_log[14].idx), 64'd0);
      checkValue("lit_one_len", 64'(model_log[14].len), 64'd1);
    end
    checkValue("results_taken", 64'(dut_log_cnt), 64'(model_log.size()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
